// File: rtl/ov5640_iic_pkg.sv
// Shared types and constants for the OV5640 SCCB register-port target.
`timescale 1ns/1ps
package ov5640_iic_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [7:0] DEFAULT_DEV_ID = 8'h78;
    localparam logic       ACK_BIT        = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_AH,
        ST_AH_ACK,
        ST_AL,
        ST_AL_ACK,
        ST_WDAT,
        ST_WDAT_ACK,
        ST_RDAT,
        ST_RACK,
        ST_IGNORE
    } iic_state_e;

    // Byte state that follows a target-driven ACK slot on the write path.
    function automatic iic_state_e ack_next(input iic_state_e s);
        case (s)
            ST_DEV_ACK:  return ST_AH;
            ST_AH_ACK:   return ST_AL;
            ST_AL_ACK:   return ST_WDAT;
            ST_WDAT_ACK: return ST_WDAT;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/iic_line_sync.sv
// SCL/SDA synchronizers plus edge, START and STOP detection for IIC targets.
`timescale 1ns/1ps
module iic_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_c_o,
    output logic scl_fall_c_o,
    output logic sda_c_o,
    output logic start_c_o,
    output logic stop_c_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;

    // Idle bus is high, so every stage resets to 1 to avoid a false edge.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s        = scl_sync_q[SYNC_STAGES-1];
    assign sda_s        = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_c_o = scl_s & ~scl_hist_q;
    assign scl_fall_c_o = ~scl_s & scl_hist_q;
    assign sda_c_o      = sda_s;
    assign start_c_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_c_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/ov5640_sccb_target.sv
// SCCB target emulating the OV5640 register port: 16-bit pointer, write strobes, read requests.
`timescale 1ns/1ps
module ov5640_sccb_target
    import ov5640_iic_pkg::*;
#(
    parameter logic [7:0]  DEV_ID      = DEFAULT_DEV_ID,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              iic_scl,
    inout  wire               iic_sda,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

    logic scl_rise_c;
    logic scl_fall_c;
    logic sda_c;
    logic start_c;
    logic stop_c;

    iic_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .scl_i        (iic_scl),
        .sda_i        (iic_sda),
        .scl_rise_c_o (scl_rise_c),
        .scl_fall_c_o (scl_fall_c),
        .sda_c_o      (sda_c),
        .start_c_o    (start_c),
        .stop_c_o     (stop_c)
    );

    iic_state_e           state_q,   state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    shift_q,   shift_d;
    logic [ADDR_W-1:0]    addr_q,    addr_d;
    logic [DATA_W-1:0]    wdata_q,   wdata_d;
    logic                 wr_q,      wr_d;
    logic                 rd_q,      rd_d;
    logic                 drv_low_q, drv_low_d;
    logic                 busy_q,    busy_d;
    logic                 rw_q,      rw_d;

    logic [DATA_W-1:0]    byte_c;
    logic                 last_bit_c;

    assign byte_c     = {shift_q[DATA_W-2:0], sda_c};
    assign last_bit_c = (bit_cnt_q == BIT_CNT_W'(7));

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            drv_low_q <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            drv_low_q <= drv_low_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        drv_low_d = drv_low_q;
        busy_d    = busy_q;
        rw_d      = rw_q;

        // Post-write auto-increment and read-data capture complete regardless of bus events.
        if (wr_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        if (rd_q) begin
            shift_d = reg_rdata;
        end

        if (start_c) begin
            state_d   = ST_DEV;
            bit_cnt_d = '0;
            drv_low_d = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_c) begin
            state_d   = ST_IDLE;
            drv_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_AH, ST_AL, ST_WDAT: begin
                    if (scl_rise_c) begin
                        shift_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit_c) begin
                            case (state_q)
                                ST_DEV: begin
                                    if (byte_c == DEV_ID) begin
                                        rw_d    = 1'b0;
                                        state_d = ST_DEV_ACK;
                                    end else if (byte_c == (DEV_ID | 8'h01)) begin
                                        rw_d    = 1'b1;
                                        state_d = ST_DEV_ACK;
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end
                                ST_AH: begin
                                    addr_d[15:8] = byte_c;
                                    state_d      = ST_AH_ACK;
                                end
                                ST_AL: begin
                                    addr_d[7:0] = byte_c;
                                    state_d     = ST_AL_ACK;
                                end
                                default: begin
                                    wdata_d = byte_c;
                                    wr_d    = 1'b1;
                                    state_d = ST_WDAT_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First fall after bit 8 pulls SDA low, the fall after the 9th clock releases it.
                ST_DEV_ACK, ST_AH_ACK, ST_AL_ACK, ST_WDAT_ACK: begin
                    if ((state_q == ST_DEV_ACK) && rw_q && drv_low_q && scl_rise_c) begin
                        state_d   = ST_RDAT;
                        rd_d      = 1'b1;
                        bit_cnt_d = '0;
                    end else if (scl_fall_c) begin
                        if (!drv_low_q) begin
                            drv_low_d = 1'b1;
                        end else begin
                            drv_low_d = 1'b0;
                            state_d   = ack_next(state_q);
                        end
                    end
                end
                ST_RDAT: begin
                    if (scl_fall_c) begin
                        drv_low_d = !shift_q[DATA_W-1];
                        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                    end else if (scl_rise_c) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit_c) begin
                            state_d = ST_RACK;
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_fall_c) begin
                        drv_low_d = 1'b0;
                    end else if (scl_rise_c) begin
                        if (sda_c == ACK_BIT) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            rd_d    = 1'b1;
                            state_d = ST_RDAT;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign iic_sda   = drv_low_q ? 1'b0 : 1'bz;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ov5640_sccb_target.sv
// Bench for ov5640_sccb_target: bit-banged SCCB master, register-port model and frame-level reference.
`timescale 1ns/1ps
module tb_ov5640_sccb_target;

    localparam int unsigned SYNC = 2;
    localparam int          Q    = 50;

    typedef logic [7:0] bq_t[$];

    logic        sclk      = 1'b0;
    logic        s_rst_n   = 1'b0;
    logic        scl_m     = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         iic_sda;
    logic        reg_wr;
    logic        reg_rd;
    logic        busy;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;

    int tests = 0;
    int fails = 0;

    assign iic_sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (iic_sda);

    always #5 sclk = ~sclk;

    ov5640_sccb_target #(
        .DEV_ID      (8'h78),
        .SYNC_STAGES (SYNC)
    ) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .iic_scl   (scl_m),
        .iic_sda   (iic_sda),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register-file model and event logs, observed mid-cycle.
    logic [7:0]  mem [0:65535];
    int unsigned cyc = 0;
    int unsigned rise8_cyc = 0;
    int          dut_low_cnt = 0;
    int          busy_rise_cnt = 0;
    logic        busy_prev = 1'b0;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int unsigned wr_lat_q[$];
    logic [15:0] rd_addr_q[$];

    always @(posedge sclk) cyc = cyc + 1;

    always @(negedge sclk) begin
        if (reg_wr === 1'b1) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
            wr_lat_q.push_back(cyc - rise8_cyc);
        end
        if (reg_rd === 1'b1) rd_addr_q.push_back(reg_addr);
        if (iic_sda === 1'b0 && !m_sda_low) dut_low_cnt = dut_low_cnt + 1;
        if (busy === 1'b1 && busy_prev === 1'b0) busy_rise_cnt = busy_rise_cnt + 1;
        busy_prev = busy;
        reg_rdata = mem[reg_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_lat_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            #Q m_sda_low = 1'b0;
            #Q scl_m = 1'b1;
            #Q;
        end else begin
            m_sda_low = 1'b0;
            #Q;
        end
        m_sda_low = 1'b1;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        #Q m_sda_low = 1'b1;
        #Q scl_m = 1'b1;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic send_bit(input logic b, input logic mark);
        #Q m_sda_low = !b;
        #Q scl_m = 1'b1;
        if (mark) rise8_cyc = cyc;
        #(2*Q) scl_m = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0);
        m_sda_low = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        #(2*Q) scl_m = 1'b1;
        #Q ack = (iic_sda === 1'b0);
        #Q scl_m = 1'b0;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = 1'b0;
            #(2*Q) scl_m = 1'b1;
            #Q b[i] = (iic_sda !== 1'b0);
            #Q scl_m = 1'b0;
        end
        #Q m_sda_low = master_ack;
        #Q scl_m = 1'b1;
        #(2*Q) scl_m = 1'b0;
        m_sda_low = 1'b0;
    endtask

    task automatic write_frame(input logic [7:0] id, input logic [15:0] addr,
                               input bq_t data, output int acks);
        logic a;
        acks = 0;
        bus_start();
        write_byte(id, a);          acks += int'(a);
        write_byte(addr[15:8], a);  acks += int'(a);
        write_byte(addr[7:0], a);   acks += int'(a);
        foreach (data[i]) begin
            write_byte(data[i], a); acks += int'(a);
        end
        bus_stop();
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        #23;
        tests++; if (reg_wr !== 1'b0)       begin fails++; $display("FAIL reset_reg_wr got %b want 0", reg_wr); end
        tests++; if (reg_rd !== 1'b0)       begin fails++; $display("FAIL reset_reg_rd got %b want 0", reg_rd); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (reg_addr !== 16'h0000) begin fails++; $display("FAIL reset_reg_addr got %h want 0000", reg_addr); end
        tests++; if (reg_wdata !== 8'h00)   begin fails++; $display("FAIL reset_reg_wdata got %h want 00", reg_wdata); end
        tests++; if (iic_sda !== 1'b1)      begin fails++; $display("FAIL reset_sda got %b want 1", iic_sda); end
        s_rst_n = 1'b1;
        @(negedge sclk);
        #2;
    endtask

    task automatic test_single_write(input string tag);
        logic a;
        int   acks = 0;
        clear_logs();
        bus_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_in_frame got %b want 1", tag, busy); end
        write_byte(8'h78, a); acks += int'(a);
        write_byte(8'h30, a); acks += int'(a);
        write_byte(8'h08, a); acks += int'(a);
        write_byte(8'h82, a); acks += int'(a);
        bus_stop();
        tests++; if (acks != 4) begin fails++; $display("FAIL %s_acks got %0d want 4", tag, acks); end
        tests++;
        if (wr_addr_q.size() != 1) begin
            fails++; $display("FAIL %s_wr_count got %0d want 1", tag, wr_addr_q.size());
        end else begin
            tests++; if (wr_addr_q[0] !== 16'h3008) begin fails++; $display("FAIL %s_wr_addr got %h want 3008", tag, wr_addr_q[0]); end
            tests++; if (wr_data_q[0] !== 8'h82)    begin fails++; $display("FAIL %s_wr_data got %h want 82", tag, wr_data_q[0]); end
            tests++; if (wr_lat_q[0] != SYNC + 1)   begin fails++; $display("FAIL %s_wr_latency got %0d want %0d", tag, wr_lat_q[0], SYNC + 1); end
        end
        tests++; if (reg_addr !== 16'h3009) begin fails++; $display("FAIL %s_final_addr got %h want 3009", tag, reg_addr); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL %s_busy_after_stop got %b want 0", tag, busy); end
    endtask

    // Case 0 is the fixed burst, case 1 crosses FFFF->0000, the rest are random.
    task automatic test_burst_write();
        for (int k = 0; k < 5; k++) begin
            logic [15:0] base;
            bq_t         d;
            int          acks;
            int          n;
            d = {};
            if (k == 0) begin
                base = 16'h503D; d = '{8'h11, 8'h22, 8'h33};
            end else if (k == 1) begin
                base = 16'hFFFF; d = '{8'($urandom), 8'($urandom)};
            end else begin
                base = 16'($urandom);
                n = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            end
            n = d.size();
            clear_logs();
            write_frame(8'h78, base, d, acks);
            tests++; if (acks != 3 + n) begin fails++; $display("FAIL burst%0d_acks got %0d want %0d", k, acks, 3 + n); end
            tests++;
            if (wr_addr_q.size() != n) begin
                fails++; $display("FAIL burst%0d_wr_count got %0d want %0d", k, wr_addr_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    logic [15:0] ea;
                    ea = base + 16'(i);
                    tests++; if (wr_addr_q[i] !== ea)   begin fails++; $display("FAIL burst%0d_addr%0d got %h want %h", k, i, wr_addr_q[i], ea); end
                    tests++; if (wr_data_q[i] !== d[i]) begin fails++; $display("FAIL burst%0d_data%0d got %h want %h", k, i, wr_data_q[i], d[i]); end
                end
            end
            tests++;
            if (reg_addr !== 16'(base + 16'(n))) begin
                fails++; $display("FAIL burst%0d_final_addr got %h want %h", k, reg_addr, 16'(base + 16'(n)));
            end
        end
    endtask

    task automatic test_wrong_id();
        for (int k = 0; k < 3; k++) begin
            logic [7:0]  id;
            logic [15:0] addr;
            bq_t         d;
            int          acks;
            int          low0;
            int          br0;
            d = {};
            if (k == 0) begin
                id = 8'h42; addr = 16'h1234;
            end else begin
                do id = 8'($urandom); while (id == 8'h78 || id == 8'h79);
                addr = 16'($urandom);
                d.push_back(8'($urandom));
            end
            clear_logs();
            low0 = dut_low_cnt;
            br0  = busy_rise_cnt;
            write_frame(id, addr, d, acks);
            tests++; if (acks != 0)               begin fails++; $display("FAIL wrongid%0d_acks got %0d want 0", k, acks); end
            tests++; if (dut_low_cnt != low0)     begin fails++; $display("FAIL wrongid%0d_sda_driven got %0d cycles want 0", k, dut_low_cnt - low0); end
            tests++; if (wr_addr_q.size() != 0)   begin fails++; $display("FAIL wrongid%0d_wr_count got %0d want 0", k, wr_addr_q.size()); end
            tests++; if (rd_addr_q.size() != 0)   begin fails++; $display("FAIL wrongid%0d_rd_count got %0d want 0", k, rd_addr_q.size()); end
            tests++; if (busy_rise_cnt != br0 + 1) begin fails++; $display("FAIL wrongid%0d_busy_rises got %0d want 1", k, busy_rise_cnt - br0); end
            tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL wrongid%0d_busy got %b want 0", k, busy); end
        end
    endtask

    // Write pointer, repeated start, read n bytes (ACK all but the last).
    task automatic test_read();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] base;
            logic [7:0]  exp [0:3];
            logic [7:0]  got;
            logic        a;
            int          acks;
            int          n;
            if (k == 0) begin
                base = 16'h300A; n = 2; exp[0] = 8'h56; exp[1] = 8'h40;
            end else begin
                base = 16'($urandom);
                n = int'($urandom_range(1, 3));
                for (int i = 0; i < n; i++) exp[i] = 8'($urandom);
            end
            for (int i = 0; i < n; i++) mem[16'(base + 16'(i))] = exp[i];
            clear_logs();
            acks = 0;
            bus_start();
            write_byte(8'h78, a);      acks += int'(a);
            write_byte(base[15:8], a); acks += int'(a);
            write_byte(base[7:0], a);  acks += int'(a);
            bus_start();
            write_byte(8'h79, a);      acks += int'(a);
            for (int i = 0; i < n; i++) begin
                read_byte(i < n - 1, got);
                tests++; if (got !== exp[i]) begin fails++; $display("FAIL read%0d_byte%0d got %h want %h", k, i, got, exp[i]); end
            end
            bus_stop();
            tests++; if (acks != 4) begin fails++; $display("FAIL read%0d_acks got %0d want 4", k, acks); end
            tests++;
            if (rd_addr_q.size() != n) begin
                fails++; $display("FAIL read%0d_rd_count got %0d want %0d", k, rd_addr_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    tests++;
                    if (rd_addr_q[i] !== 16'(base + 16'(i))) begin
                        fails++; $display("FAIL read%0d_rd_addr%0d got %h want %h", k, i, rd_addr_q[i], 16'(base + 16'(i)));
                    end
                end
            end
            tests++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL read%0d_wr_count got %0d want 0", k, wr_addr_q.size()); end
            tests++;
            if (reg_addr !== 16'(base + 16'(n - 1))) begin
                fails++; $display("FAIL read%0d_final_addr got %h want %h", k, reg_addr, 16'(base + 16'(n - 1)));
            end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL read%0d_busy got %b want 0", k, busy); end
        end
    endtask

    task automatic test_abort_stop();
        logic a;
        int   acks = 0;
        clear_logs();
        bus_start();
        write_byte(8'h78, a); acks += int'(a);
        write_byte(8'h30, a); acks += int'(a);
        write_byte(8'h08, a); acks += int'(a);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
        m_sda_low = 1'b0;
        bus_stop();
        tests++; if (acks != 3)             begin fails++; $display("FAIL abort_acks got %0d want 3", acks); end
        tests++; if (wr_addr_q.size() != 0) begin fails++; $display("FAIL abort_wr_count got %0d want 0", wr_addr_q.size()); end
        tests++; if (reg_addr !== 16'h3008) begin fails++; $display("FAIL abort_addr got %h want 3008", reg_addr); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_ack();
        logic a;
        bus_start();
        write_byte(8'h78, a);
        send_bits(8'h30);
        #Q;
        tests++; if (iic_sda !== 1'b0) begin fails++; $display("FAIL midack_ack_driven got %b want 0", iic_sda); end
        s_rst_n = 1'b0;
        #1;
        tests++; if (iic_sda !== 1'b1)      begin fails++; $display("FAIL midack_sda_released got %b want 1", iic_sda); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL midack_busy got %b want 0", busy); end
        tests++; if (reg_addr !== 16'h0000) begin fails++; $display("FAIL midack_addr got %h want 0000", reg_addr); end
        #20;
        s_rst_n = 1'b1;
        @(negedge sclk);
        #2;
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_single_write("single");
        test_burst_write();
        test_wrong_id();
        test_read();
        test_abort_stop();
        test_reset_mid_ack();
        test_single_write("after_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
